// File: rtl/wsn_pkg.sv
// Shared constants, FSM state type and FIFO entry layout for the wsn_rx radio receiver.
package wsn_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h2D;
  localparam logic [7:0] CRC_POLY  = 8'h07;
  localparam logic [7:0] CRC_INIT  = 8'h00;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CRC  = 2'd3
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

  // One MSB-first step of CRC-8
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/wsn_rx_fifo.sv
// Synchronous payload FIFO with per-entry last flag and sticky overflow on dropped writes.
module wsn_rx_fifo
  import wsn_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      wr_en,
  input  rx_entry_t wr_data,
  input  logic      rd_ready,
  output logic      rd_valid,
  output rx_entry_t rd_data,
  output logic      overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  rx_entry_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  logic            full;
  logic            rd_en;
  logic            wr_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign rd_en   = rd_valid & rd_ready;
  // A full FIFO still accepts a write when a read frees a slot the same cycle
  assign wr_ok   = wr_en & (~full | rd_en);
  assign count_n = count + CW'(wr_ok) - CW'(rd_en);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_n;
      rd_valid <= (count_n != '0);
      overflow <= overflow | (wr_en & ~wr_ok);
    end
  end

endmodule

// File: rtl/wsn_rx.sv
// Oversampling radio frame receiver: sync hunt, length check, payload FIFO.
// Define WSN_RX_CRC_EN to add the trailing CRC-8 byte and crc_err reporting.
module wsn_rx
  import wsn_pkg::*;
#(
  parameter int unsigned OVS        = 8,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       antena,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_last,
  output logic       frame_done,
  output logic       crc_err,
  output logic       len_err,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(OVS);

  state_t      state, state_n;
  logic        sync1, sync2, sync_q;
  logic [PW-1:0] phase;
  logic [6:0]  shift;
  logic [7:0]  shift_n;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [7:0]  cnt_n;
  logic [7:0]  len;
  logic        edge_det;
  logic        sample;
  logic        byte_done;
  logic        wr_en;
  logic        wr_last;
  logic        done_n;
  logic        lerr_n;
  rx_entry_t   wr_data;
  rx_entry_t   rd_data;
`ifdef WSN_RX_CRC_EN
  logic [7:0]  crc;
  logic        cerr_n;
`endif

  assign edge_det  = sync2 ^ sync_q;
  assign sample    = (phase == PW'(OVS / 2));
  assign shift_n   = {shift, sync2};
  assign byte_done = sample & (bit_cnt == 3'd7) & (state != ST_HUNT);
  assign cnt_n     = byte_cnt + 8'd1;
  assign wr_data   = '{last: wr_last, data: shift_n};

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_HUNT;
    else        state <= state_n;
  end

  // Next state and per-byte strobes
  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    wr_last = 1'b0;
    done_n  = 1'b0;
    lerr_n  = 1'b0;
`ifdef WSN_RX_CRC_EN
    cerr_n  = 1'b0;
`endif
    unique case (state)
      ST_HUNT: if (sample && shift_n == SYNC_BYTE) state_n = ST_LEN;
      ST_LEN: begin
        if (byte_done) begin
          if (shift_n == 8'h00 || shift_n > 8'(MAX_LEN)) begin
            lerr_n  = 1'b1;
            state_n = ST_HUNT;
          end else begin
            state_n = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          wr_en = 1'b1;
          if (cnt_n == len) begin
            wr_last = 1'b1;
`ifdef WSN_RX_CRC_EN
            state_n = ST_CRC;
`else
            state_n = ST_HUNT;
            done_n  = 1'b1;
`endif
          end
        end
      end
      ST_CRC: begin
`ifdef WSN_RX_CRC_EN
        if (byte_done) begin
          done_n  = 1'b1;
          cerr_n  = (shift_n != crc);
          state_n = ST_HUNT;
        end
`else
        state_n = ST_HUNT;
`endif
      end
      default: state_n = ST_HUNT;
    endcase
  end

  // Synchronizer, bit recovery and frame datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync_q     <= 1'b1;
      phase      <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      len        <= '0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      sync1  <= antena;
      sync2  <= sync1;
      sync_q <= sync2;
      if (edge_det)                  phase <= PW'(1);
      else if (phase == PW'(OVS - 1)) phase <= '0;
      else                           phase <= phase + PW'(1);
      if (sample) begin
        // Clearing on frame exit stops stale payload bits from aliasing a sync word
        if (state != ST_HUNT && state_n == ST_HUNT) shift <= '0;
        else                                        shift <= shift_n[6:0];
        bit_cnt <= (state == ST_HUNT) ? 3'd0 : bit_cnt + 3'd1;
      end
      if (state == ST_LEN) begin
        byte_cnt <= '0;
        if (byte_done) len <= shift_n;
      end else if (state == ST_DATA && byte_done) begin
        byte_cnt <= cnt_n;
      end
      frame_done <= done_n;
      len_err    <= lerr_n;
    end
  end

`ifdef WSN_RX_CRC_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      crc     <= CRC_INIT;
      crc_err <= 1'b0;
    end else begin
      if (sample) begin
        if (state == ST_HUNT)                        crc <= CRC_INIT;
        else if (state == ST_LEN || state == ST_DATA) crc <= crc8_step(crc, sync2);
      end
      crc_err <= cerr_n;
    end
  end
`else
  assign crc_err = 1'b0;
`endif

  wsn_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_ready (rx_ready),
    .rd_valid (rx_valid),
    .rd_data  (rd_data),
    .overflow (overflow)
  );

  assign rx_data = rd_data.data;
  assign rx_last = rd_data.last;

endmodule

// File: tb/tb_wsn_rx.sv
// Scoreboard bench for wsn_rx: directed frames drive the radio line, a monitor checks bytes and pulses.
module tb_wsn_rx;

  localparam int OVS        = 8;
  localparam int MAX_LEN    = 16;
  localparam int FIFO_DEPTH = 16;

  typedef logic [7:0] byteq_t[$];
  typedef logic       bitq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       antena = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_last, frame_done, crc_err, len_err, overflow;

  logic [8:0] exp_b[$];
  logic [2:0] exp_e[$];
  logic [8:0] mon_b;
  logic [2:0] mon_e;
  int checks = 0;
  int errors = 0;
  int jtab[9] = '{0, 2, -1, 2, 0, -1, 1, -2, 0};

  always #5 clk = ~clk;

  wsn_rx #(.OVS(OVS), .MAX_LEN(MAX_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .antena(antena), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_last(rx_last), .frame_done(frame_done), .crc_err(crc_err),
    .len_err(len_err), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: bytes on handshake, status pulses as {len_err, frame_done, crc_err}
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got %0h expected none", {rx_last, rx_data});
      end else begin
        mon_b = exp_b.pop_front();
        check("rx_byte", 32'({rx_last, rx_data}), 32'(mon_b));
      end
    end
    if (frame_done || len_err || crc_err) begin
      if (exp_e.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got %0b expected none", {len_err, frame_done, crc_err});
      end else begin
        mon_e = exp_e.pop_front();
        check("status_pulse", 32'({len_err, frame_done, crc_err}), 32'(mon_e));
      end
    end
  end

  function automatic logic [7:0] crc8(input byteq_t b);
    logic [7:0] c = 8'h00;
    for (int i = 1; i < b.size(); i++) begin
      c = c ^ b[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic bitq_t to_bits(input byteq_t b, input int pre);
    bitq_t q;
    for (int i = 0; i < pre; i++) q.push_back((i % 2) == 0);
    for (int i = 0; i < b.size(); i++)
      for (int k = 7; k >= 0; k--) q.push_back(b[i][k]);
    return q;
  endfunction

  // Drive bits at OVS clocks each; optional edge jitter and a one-cycle reset at bit rst_at
  task automatic send_bits(input bitq_t bits, input bit jit, input int rst_at);
    int   ts[$];
    logic tv[$];
    logic cur = 1'b1;
    int   k = 0;
    for (int i = 0; i < bits.size(); i++) begin
      if (bits[i] !== cur) begin
        ts.push_back(OVS * i + (jit ? jtab[k % 9] : 0));
        tv.push_back(bits[i]);
        cur = bits[i];
        k++;
      end
    end
    for (int t = 0; t < OVS * bits.size() + 48; t++) begin
      if (ts.size() != 0 && ts[0] == t) begin
        antena = tv.pop_front();
        void'(ts.pop_front());
      end
      reset = (t != OVS * rst_at);
      @(posedge clk); #1;
      if (t == OVS * rst_at)
        check("reset_mid_outputs",
              32'({rx_valid, rx_last, frame_done, crc_err, len_err, overflow, rx_data}), 32'd0);
    end
    antena = 1'b1;
    reset  = 1'b1;
  endtask

  task automatic run_frame(input byteq_t pay, input bit bad, input bit jit, input int pre,
                           input int keep);
    byteq_t q;
    q = '{8'h2D, 8'(pay.size())};
    for (int i = 0; i < pay.size(); i++) begin
      q.push_back(pay[i]);
      if (i < keep) exp_b.push_back({(i == pay.size() - 1), pay[i]});
    end
`ifdef WSN_RX_CRC_EN
    q.push_back(crc8(q) ^ {7'b0, bad});
    exp_e.push_back(bad ? 3'b011 : 3'b010);
`else
    exp_e.push_back(3'b010);
`endif
    send_bits(to_bits(q, pre), jit, -1);
  endtask

  task automatic wait_idle(input int budget, input bit bytes_too);
    int n = 0;
    while ((exp_e.size() != 0 || (bytes_too && exp_b.size() != 0)) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes %0d pulses pending expected 0", exp_b.size(), exp_e.size());
    end
  endtask

  initial begin
    byteq_t p1, p2, q;
    bitq_t  bits;
    int     rst;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({rx_valid, rx_last, frame_done, crc_err, len_err, overflow, rx_data}), 32'd0);
    reset = 1'b1;
    rx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    run_frame('{8'h11, 8'h22, 8'h33}, 1'b0, 1'b0, 8, 3);
    wait_idle(300, 1'b1);
`ifdef WSN_RX_CRC_EN
    run_frame('{8'h11, 8'h22, 8'h33}, 1'b1, 1'b0, 8, 3);
    wait_idle(300, 1'b1);
`endif
    run_frame('{8'hA5}, 1'b0, 1'b0, 8, 1);
    wait_idle(300, 1'b1);

    // Illegal lengths abort with no payload written
    exp_e.push_back(3'b100);
    send_bits(to_bits('{8'h2D, 8'h00}, 8), 1'b0, -1);
    wait_idle(300, 1'b1);
    exp_e.push_back(3'b100);
    send_bits(to_bits('{8'h2D, 8'(MAX_LEN + 1)}, 8), 1'b0, -1);
    wait_idle(300, 1'b1);
    run_frame('{8'h2D, 8'hFF}, 1'b0, 1'b0, 8, 2);
    wait_idle(300, 1'b1);

    // Consumer stalled: frame 1 fills the FIFO, frame 2 is dropped entirely
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      p1.push_back(8'(8'h40 + i));
      p2.push_back(8'(8'h80 + i));
    end
    run_frame(p1, 1'b0, 1'b0, 8, 16);
    check("overflow_after_f1", 32'(overflow), 32'd0);
    run_frame(p2, 1'b0, 1'b0, 8, 0);
    wait_idle(300, 1'b0);
    check("overflow_set", 32'(overflow), 32'd1);
    check("stall_head", 32'({rx_valid, rx_last, rx_data}), 32'({1'b1, 1'b0, 8'h40}));
    repeat (10) @(posedge clk);
    #1;
    check("stall_hold", 32'({rx_valid, rx_last, rx_data}), 32'({1'b1, 1'b0, 8'h40}));
    rx_ready = 1'b1;
    wait_idle(300, 1'b1);

    // Reset pulse during payload byte 2 discards the frame and clears overflow
    q = '{8'h2D, 8'h03, 8'h11, 8'h22, 8'h33};
    exp_b.push_back(9'h011);
    bits = to_bits(q, 8);
    rst = 8 + 24 + 2;
    while (bits.size() > rst + 1) void'(bits.pop_back());
    send_bits(bits, 1'b0, rst);
    wait_idle(300, 1'b1);
    check("overflow_cleared", 32'(overflow), 32'd0);
    run_frame('{8'h5A, 8'hC3}, 1'b0, 1'b0, 8, 2);
    wait_idle(300, 1'b1);

    // Jittered edges behind a long alternating preamble
    run_frame('{8'hA5, 8'h5A, 8'h0F}, 1'b0, 1'b1, 32, 3);
    wait_idle(300, 1'b1);

    check("queues_empty", 32'(exp_b.size() + exp_e.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wsn_rx.md
WSN_RX -- requirements
Module: wsn_rx

Interface
REQ-001 Parameter OVS, default 8, clocks per antenna bit (even, >=4).
REQ-002 Parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-003 Parameter FIFO_DEPTH, default 16, payload byte buffer entries (power of 2).
REQ-004 clk  input  1  system clock, the only clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 antena  input  1  shared radio line, asynchronous to clk, idle high.
REQ-007 rx_data  output  8  buffered payload byte.
REQ-008 rx_valid  output  1  rx_data valid.
REQ-009 rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-010 rx_last  output  1  qualifies rx_data as the final byte of its frame.
REQ-011 frame_done  output  1  one-cycle pulse, frame completed.
REQ-012 crc_err  output  1  one-cycle pulse with frame_done, CRC mismatch.
REQ-013 len_err  output  1  one-cycle pulse, illegal length byte, frame aborted.
REQ-014 overflow  output  1  sticky, payload byte lost to a full FIFO; cleared only by reset.

Function
REQ-015 antena passes through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-016 Phase counter 0..OVS-1: set to 1 on any synchronized edge, otherwise increments and wraps; one bit is sampled when phase==OVS/2.
REQ-017 Frame format: preamble (ignored), SYNC byte 8'h2D, LEN byte, LEN payload bytes, CRC byte; all bytes MSB first.
REQ-018 FSM states: HUNT, LEN, DATA, CRC.
REQ-019 HUNT: 8-bit sample shift register; on match with 8'h2D go to LEN; the bit counter is cleared.
REQ-020 LEN: after 8 bits, LEN==0 or LEN>MAX_LEN -> len_err pulse, go to HUNT; otherwise go to DATA.
REQ-021 DATA: each completed byte is written to the FIFO; after LEN bytes go to CRC.
REQ-022 The byte that completes DATA is written with last=1; last is stored per FIFO entry and driven on rx_last.
REQ-023 CRC: CRC-8, polynomial 0x07, init 8'h00, computed bitwise over the LEN and payload bytes.
REQ-024 CRC completion: on the 8th CRC bit, frame_done pulses the next cycle, crc_err=1 if the received byte differs from the computed CRC; then go to HUNT.
REQ-025 Payload bytes are released to the FIFO without waiting for the CRC check.
REQ-026 FIFO write-to-rx_valid latency: 1 cycle.
REQ-027 Simultaneous read and write on a full FIFO is legal, with no overflow.
REQ-028 Simultaneous read and write on an empty FIFO: the write is visible the next cycle.
REQ-029 FIFO full on write: the byte is dropped, overflow is set, and the FSM continues.
REQ-030 If the dropped byte is the last byte, rx_last is never presented for that frame.
REQ-031 rx_data and rx_last are held stable while rx_valid=1 and rx_ready=0.

Reset
REQ-032 Reset low: FSM->HUNT; shift, phase and bit counters->0; synchronizer flops->1; FIFO empty.
REQ-033 Reset low: all outputs 0 (rx_data 8'h00).
REQ-034 Reset asserted mid-frame discards the partial frame and all buffered bytes, with no pulses.

Configuration
REQ-035 Macro WSN_RX_CRC_EN defined: the CRC state exists and crc_err is driven as in REQ-024.
REQ-036 Macro WSN_RX_CRC_EN undefined: the frame has no CRC byte, DATA goes directly to HUNT, frame_done pulses the cycle after the last payload byte is written, and crc_err is tied 0.

Structure
REQ-037 Package wsn_pkg holds SYNC_BYTE (8'h2D), CRC_POLY (8'h07), CRC_INIT (8'h00) and the FSM state typedef.
REQ-038 Sub-module wsn_rx_fifo: synchronous FIFO, 9-bit entries (last + data), parameter FIFO_DEPTH, same clk/reset.

Verification
REQ-039 OVS=8, frame 2D,03,11,22,33,CRC 8'hXX computed, rx_ready=1 -> rx_data 11,22,33; rx_last on 33; frame_done=1, crc_err=0.
REQ-040 Same frame with the CRC byte XORed 8'h01 -> three bytes delivered, frame_done=1, crc_err=1.
REQ-041 LEN=0 and LEN=17 (MAX_LEN=16) -> len_err pulse, no FIFO write, next valid frame decoded correctly.
REQ-042 FIFO_DEPTH=16, rx_ready=0, two 16-byte frames -> first 16 bytes retained, overflow=1, then draining yields bytes of frame 1 in order.
REQ-043 Reset low for 1 cycle during DATA byte 2 -> outputs 0, no frame_done; next frame received intact.
REQ-044 Bit edges jittered +/-2 clocks, SYNC preceded by 32 preamble bits 1010... -> correct bytes, with no false sync in the preamble.
